// File: rtl/forward_buf.sv
// Multi-entry write-back forwarding buffer with two read ports.
// Optional hit counter when FORWARD_BUF_PERF_EN is defined.
module forward_buf #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 3,
  parameter int AW    = 5
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            we_i,
  input  logic [AW-1:0]   rd_i,
  input  logic [XLEN-1:0] dat_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [AW-1:0]   ra_i,
  input  logic [AW-1:0]   rb_i,
  output logic            hita_o,
  output logic            hitb_o,
  output logic [XLEN-1:0] qa_o,
  output logic [XLEN-1:0] qb_o
`ifdef FORWARD_BUF_PERF_EN
  ,
  output logic [31:0]     fwdcnt_o
`endif
);

  logic [DEPTH-1:0] v_q;
  logic [AW-1:0]    rd_q  [DEPTH];
  logic [XLEN-1:0]  dat_q [DEPTH];

  // History shift register: flush clears, stall holds, else shift in live write
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= '0;
        dat_q[i] <= '0;
      end
    end else if (flush_i) begin
      v_q <= '0;
    end else if (!stall_i) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        v_q[i]   <= v_q[i-1];
        rd_q[i]  <= rd_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
      v_q[0]   <= we_i && (rd_i != '0);
      rd_q[0]  <= rd_i;
      dat_q[0] <= dat_i;
    end
  end

  // Lookup oldest to youngest so the youngest match overrides, live last
  always_comb begin
    hita_o = 1'b0;
    hitb_o = 1'b0;
    qa_o   = '0;
    qb_o   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (v_q[i] && rd_q[i] == ra_i && ra_i != '0) begin
        hita_o = 1'b1;
        qa_o   = dat_q[i];
      end
      if (v_q[i] && rd_q[i] == rb_i && rb_i != '0) begin
        hitb_o = 1'b1;
        qb_o   = dat_q[i];
      end
    end
    if (we_i && rd_i == ra_i && ra_i != '0) begin
      hita_o = 1'b1;
      qa_o   = dat_i;
    end
    if (we_i && rd_i == rb_i && rb_i != '0) begin
      hitb_o = 1'b1;
      qb_o   = dat_i;
    end
  end

`ifdef FORWARD_BUF_PERF_EN
  // Saturating count of cycles with any forward hit; flush does not clear it
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)
      fwdcnt_o <= '0;
    else if ((hita_o | hitb_o) && fwdcnt_o != 32'hFFFF_FFFF)
      fwdcnt_o <= fwdcnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_forward_buf.sv
// Directed self-checking bench for forward_buf.
// Checks the counter too when FORWARD_BUF_PERF_EN is defined.
module tb_forward_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  rd;
  logic [63:0] dat;
  logic        stall;
  logic        flush;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic        hita;
  logic        hitb;
  logic [63:0] qa;
  logic [63:0] qb;
`ifdef FORWARD_BUF_PERF_EN
  logic [31:0] fwdcnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [63:0] BEEF = 64'hDEAD_BEEF_FEED_FACE;

  forward_buf #(.XLEN(64), .DEPTH(3), .AW(5)) dut (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .we_i     (we),
    .rd_i     (rd),
    .dat_i    (dat),
    .stall_i  (stall),
    .flush_i  (flush),
    .ra_i     (ra),
    .rb_i     (rb),
    .hita_o   (hita),
    .hitb_o   (hitb),
    .qa_o     (qa),
    .qb_o     (qb)
`ifdef FORWARD_BUF_PERF_EN
    ,
    .fwdcnt_o (fwdcnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at negedge, settle, leave checks to caller
  task automatic drive(input logic w, input logic [4:0] d,
                       input logic [63:0] x, input logic s,
                       input logic f, input logic [4:0] a,
                       input logic [4:0] b);
    @(negedge clk);
    we = w; rd = d; dat = x; stall = s; flush = f; ra = a; rb = b;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    we = 0; rd = 0; dat = 0; stall = 0; flush = 0; ra = 15; rb = 21;
    #3;
    chk("rst_hita", {63'd0, hita}, 64'd0);
    chk("rst_hitb", {63'd0, hitb}, 64'd0);
    chk("rst_qa", qa, 64'd0);
    chk("rst_qb", qb, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // live forward then aging through history
    drive(1, 19, BEEF, 0, 0, 19, 21);
    chk("live_hita", {63'd0, hita}, 64'd1);
    chk("live_qa", qa, BEEF);
    chk("live_hitb", {63'd0, hitb}, 64'd0);
    chk("live_qb", qb, 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 19, 19);
      chk($sformatf("age%0d_qa", i), qa, BEEF);
      chk($sformatf("age%0d_qb", i), qb, BEEF);
      chk($sformatf("age%0d_hit", i), {62'd0, hita, hitb}, 64'd3);
    end
    drive(0, 0, 0, 0, 0, 19, 19);
    chk("aged_out_hit", {62'd0, hita, hitb}, 64'd0);
    chk("aged_out_qa", qa, 64'd0);

    // youngest wins
    drive(1, 7, 64'h1111, 0, 0, 7, 0);
    drive(1, 7, 64'h2222, 0, 0, 7, 0);
    chk("young_e0", qa, 64'h2222);
    drive(1, 7, 64'h3333, 0, 0, 7, 0);
    chk("young_live", qa, 64'h3333);
    drive(0, 0, 0, 0, 0, 7, 7);
    chk("young_hist_a", qa, 64'h3333);
    chk("young_hist_b", qb, 64'h3333);

    // x0 guard
    drive(1, 0, '1, 0, 0, 0, 0);
    chk("x0_live_hit", {62'd0, hita, hitb}, 64'd0);
    chk("x0_live_q", qa | qb, 64'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("x0_hist_hit", {62'd0, hita, hitb}, 64'd0);
    chk("x0_hist_q", qa | qb, 64'd0);

    // stall holds history, live write not captured
    drive(1, 5, 64'hAB, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 6, 64'h66, 1, 0, 5, 6);
      chk($sformatf("stall%0d_qa", i), qa, 64'hAB);
      chk($sformatf("stall%0d_qb", i), qb, 64'h66);
    end
    drive(0, 0, 0, 0, 0, 5, 6);
    chk("post_stall_qa", qa, 64'hAB);
    chk("post_stall_hitb", {63'd0, hitb}, 64'd0);
    drive(0, 0, 0, 1, 1, 5, 0);
    chk("flush_cyc_qa", qa, 64'hAB);
    drive(0, 0, 0, 0, 0, 5, 0);
    chk("flushed_hita", {63'd0, hita}, 64'd0);
    chk("flushed_qa", qa, 64'd0);

    // flush still forwards live input that cycle
    drive(1, 3, 64'h33, 0, 1, 3, 3);
    chk("flush_live_qa", qa, 64'h33);
    drive(0, 0, 0, 0, 0, 3, 3);
    chk("flush_nocap", {62'd0, hita, hitb}, 64'd0);

    // async reset mid-history
    drive(1, 9, 64'h99, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 9, 9);
    chk("pre_rst_qa", qa, 64'h99);
    rst_n = 1'b0;
    #1;
    chk("async_rst_hit", {62'd0, hita, hitb}, 64'd0);
    chk("async_rst_q", qa | qb, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef FORWARD_BUF_PERF_EN
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    chk("cnt_rst0", {32'd0, fwdcnt}, 64'd0);
    drive(1, 1, 64'h1, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 1, 1, 0);
    drive(1, 2, 64'h2, 0, 1, 0, 2);
    drive(1, 4, 64'h4, 0, 1, 4, 4);
    drive(0, 0, 0, 0, 1, 1, 2);
    drive(1, 8, 64'h8, 0, 1, 8, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("cnt_four", {32'd0, fwdcnt}, 64'd4);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("cnt_after_flush", {32'd0, fwdcnt}, 64'd4);
    rst_n = 1'b0;
    #1;
    chk("cnt_after_rst", {32'd0, fwdcnt}, 64'd0);
    rst_n = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/forward_buf.md
Name: forward_buf

Overview:
Parametrised successor to the single-entry forwarder. It keeps a short history of the most recent register write-backs and serves two read ports from that history. Each read port returns the youngest matching value. It sits between the register file read stage and the execute stage, covering DEPTH cycles of write-back latency that the register file cannot yet see. A stall input holds the history and a flush input invalidates it.

Parameters:
XLEN, 64, data width of each register value
DEPTH, 3, number of registered history entries (1..8); the live write-back input counts as an extra, zeroth-priority source
AW, 5, register address width

Ports:
clk_i  input  1  clock; all state changes on rising edge
reset_ni  input  1  asynchronous, active-low reset
we_i  input  1  write-back valid this cycle
rd_i  input  AW  write-back destination register
dat_i  input  XLEN  write-back data
stall_i  input  1  hold history; no shift on this edge
flush_i  input  1  invalidate all history entries on this edge
ra_i  input  AW  read port A register address
rb_i  input  AW  read port B register address
hita_o  output  1  port A matched a live or history write
hitb_o  output  1  port B matched a live or history write
qa_o  output  XLEN  forwarded value for A; 0 on miss
qb_o  output  XLEN  forwarded value for B; 0 on miss

Behaviour:
- State: DEPTH entries E[0..DEPTH-1], each holding {v, rd, dat}. E[0] is the youngest.
- Reset (reset_ni low, asynchronous): all v, rd and dat fields cleared to 0. With history empty and we_i=0, all outputs are 0. Reset asserted mid-stream discards all history immediately, with no clock edge needed.
- Lookup is combinational with zero latency. Sources in priority order: the live input {we_i, rd_i, dat_i}, then E[0], E[1], … E[DEPTH-1].
  - The first source with v=1, rd==ra_i and rd!=0 drives hita_o=1 and qa_o=its dat. Port B works the same way with rb_i.
  - Miss: hit=0, q=0.
- Register 0 never hits, from any source, even if written with we_i=1.
- Ports A and B are independent. ra_i==rb_i gives identical outputs.
- Rising-edge update, in priority order:
  1. flush_i=1: every E[i].v <= 0. The live input is not captured. rd and dat fields may hold.
  2. else stall_i=1: all entries hold. The live input is not captured; the producer re-presents it after the stall.
  3. else shift: E[i+1] <= E[i] for i < DEPTH-1; E[0] <= {we_i && rd_i!=0, rd_i, dat_i}. E[DEPTH-1] falls off.
- flush_i overrides stall_i. During flush the live input still forwards combinationally in that same cycle.
- Duplicate rd values may coexist across entries. Priority guarantees the youngest wins.
- No X propagation: a slot with v=0 contributes nothing, whatever its rd and dat fields contain.

Optional Feature:
FORWARD_BUF_PERF_EN.
- Defined: adds output port fwdcnt_o (32 bits). It resets to 0 and increments by 1 on each rising edge where hita_o|hitb_o is 1. It saturates at 0xFFFFFFFF. It still counts during stall. flush_i does not clear it.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
1. Reset, then we_i=0, ra_i=15, rb_i=21 -> hita_o=hitb_o=0, qa_o=qb_o=0.
2. Live forward with DEPTH=3. Cycle 0: we_i=1, rd_i=19, dat_i=64'hDEADBEEFFEEDFACE, ra_i=19, rb_i=21 -> hita_o=1, qa_o=DEADBEEFFEEDFACE, hitb_o=0 in the same cycle. Then we_i=0 and read ra_i=rb_i=19 on the next 3 cycles -> both hit with that value. On the 4th cycle -> both miss and read 0.
3. Youngest wins. Write r7=0x1111, then r7=0x2222, then live r7=0x3333 -> qa_o=0x3333. The next cycle with we_i=0 -> qa_o=0x3333 (from E[0]), not 0x2222.
4. x0 guard. we_i=1, rd_i=0, dat_i=all-ones, ra_i=rb_i=0 -> no hit and 0 output, both live and on the following cycle.
5. Stall/flush. Write r5=0xAB, then assert stall_i for 5 cycles -> r5 still hits, with a live write to r6 during the stall not captured. Then assert flush_i together with stall_i -> the next cycle r5 misses. Separately, assert reset_ni low mid-history -> immediate miss on all ports.
6. With FORWARD_BUF_PERF_EN defined: 4 cycles with any hit, interleaved with 2 miss cycles -> fwdcnt_o=4. After a flush fwdcnt_o is still 4. After reset fwdcnt_o=0.
